// File: rtl/mem_lsu_stage_pkg.sv
// Shared types for the RV32I memory-access stage: memory-op encodings, bus widths and helpers.
package mem_lsu_stage_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegW     = 32;
  localparam int unsigned MemOpW   = 4;

  typedef enum logic [MemOpW-1:0] {
    MemNone = 4'd0,
    MemLb   = 4'd1,
    MemLh   = 4'd2,
    MemLw   = 4'd3,
    MemLbu  = 4'd4,
    MemLhu  = 4'd5,
    MemSb   = 4'd6,
    MemSh   = 4'd7,
    MemSw   = 4'd8
  } mem_op_e;

  function automatic logic is_mem_op(mem_op_e op);
    return op inside {MemLb, MemLh, MemLw, MemLbu, MemLhu, MemSb, MemSh, MemSw};
  endfunction

  function automatic logic is_store_op(mem_op_e op);
    return op inside {MemSb, MemSh, MemSw};
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [1:0] off);
    case (op)
      MemLh, MemLhu, MemSh: return off[0];
      MemLw, MemSw:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication / byte enables and load byte select / extension.
module lsu_align
  import mem_lsu_stage_pkg::*;
(
  input  mem_op_e          i_st_op,
  input  logic [1:0]       i_st_off,
  input  logic [RegW-1:0]  i_st_data,
  output logic [3:0]       o_be,
  output logic [RegW-1:0]  o_st_lane,
  input  mem_op_e          i_ld_op,
  input  logic [1:0]       i_ld_off,
  input  logic [RegW-1:0]  i_ld_rdata,
  output logic [RegW-1:0]  o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte enables apply to loads too so the bus sees which lanes are read.
  always_comb begin
    o_be      = 4'b0000;
    o_st_lane = '0;
    case (i_st_op)
      MemLb, MemLbu, MemSb: o_be = 4'b0001 << i_st_off;
      MemLh, MemLhu, MemSh: o_be = i_st_off[1] ? 4'b1100 : 4'b0011;
      MemLw, MemSw:         o_be = 4'b1111;
      default:              o_be = 4'b0000;
    endcase
    case (i_st_op)
      MemSb:   o_st_lane = {4{i_st_data[7:0]}};
      MemSh:   o_st_lane = {2{i_st_data[15:0]}};
      MemSw:   o_st_lane = i_st_data;
      default: o_st_lane = '0;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (i_ld_off)
      2'd0:    w_byte = i_ld_rdata[7:0];
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      default: w_byte = i_ld_rdata[31:24];
    endcase
    w_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    case (i_ld_op)
      MemLb:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      MemLbu:  o_ld_data = {24'h000000, w_byte};
      MemLh:   o_ld_data = {{16{w_half[15]}}, w_half};
      MemLhu:  o_ld_data = {16'h0000, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// RV32I MEM stage: req/gnt/rvalid load/store FSM plus the MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of masking low bits.
module mem_lsu_stage
  import mem_lsu_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic                w_enable_i,
  input  logic [RegAddrW-1:0] w_addr_i,
  input  logic [RegW-1:0]     w_data_i,
  input  logic [MemOpW-1:0]   mem_op_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [RegW-1:0]     mem_wdata_i,
  output logic                stall_o,
  output logic                req_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [3:0]          be_o,
  output logic [RegW-1:0]     wdata_o,
  input  logic                gnt_i,
  input  logic                rvalid_i,
  input  logic [RegW-1:0]     rdata_i,
  output logic                w_enable_o,
  output logic [RegAddrW-1:0] w_addr_o,
  output logic [RegW-1:0]     w_data_o,
  output logic                exc_o,
  output logic [ADDR_W-1:0]   exc_addr_o
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e                r_state;
  mem_op_e               r_op;
  logic [1:0]            r_off;
  logic                  r_ld_wen;
  logic [RegAddrW-1:0]   r_ld_waddr;
  logic                  r_req;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [3:0]            r_be;
  logic [RegW-1:0]       r_wdata;
  logic                  r_wb_en;
  logic [RegAddrW-1:0]   r_wb_addr;
  logic [RegW-1:0]       r_wb_data;

  mem_op_e               w_op;
  logic                  w_is_mem;
  logic                  w_trap;
  logic [3:0]            w_be;
  logic [RegW-1:0]       w_st_lane;
  logic [RegW-1:0]       w_ld_data;

  assign w_op     = mem_op_e'(mem_op_i);
  assign w_is_mem = is_mem_op(w_op);

  lsu_align u_align (
    .i_st_op    (w_op),
    .i_st_off   (mem_addr_i[1:0]),
    .i_st_data  (mem_wdata_i),
    .o_be       (w_be),
    .o_st_lane  (w_st_lane),
    .i_ld_op    (r_op),
    .i_ld_off   (r_off),
    .i_ld_rdata (rdata_i),
    .o_ld_data  (w_ld_data)
  );

`ifdef MISALIGN_TRAP_EN
  logic              r_exc;
  logic [ADDR_W-1:0] r_exc_addr;

  assign w_trap = (r_state == StIdle) && valid_i && w_is_mem &&
                  is_misaligned(w_op, mem_addr_i[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exc      <= 1'b0;
      r_exc_addr <= '0;
    end else begin
      r_exc <= w_trap;
      if (w_trap) r_exc_addr <= mem_addr_i;
    end
  end

  assign exc_o      = r_exc;
  assign exc_addr_o = r_exc_addr;
`else
  assign w_trap     = 1'b0;
  assign exc_o      = 1'b0;
  assign exc_addr_o = '0;
`endif

  always_comb begin
    stall_o = 1'b0;
    unique case (r_state)
      StIdle:  stall_o = valid_i && w_is_mem && !w_trap;
      StReq:   stall_o = !(gnt_i && is_store_op(r_op));
      StResp:  stall_o = !rvalid_i;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_op       <= MemNone;
      r_off      <= 2'b00;
      r_ld_wen   <= 1'b0;
      r_ld_waddr <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= '0;
      r_wb_en    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (valid_i && !w_is_mem) begin
            r_wb_en   <= w_enable_i;
            r_wb_addr <= w_addr_i;
            r_wb_data <= w_data_i;
          end else if (valid_i && !w_trap) begin
            r_op       <= w_op;
            r_off      <= mem_addr_i[1:0];
            r_ld_wen   <= w_enable_i;
            r_ld_waddr <= w_addr_i;
            r_req      <= 1'b1;
            r_we       <= is_store_op(w_op);
            r_addr     <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            r_be       <= w_be;
            r_wdata    <= w_st_lane;
            r_state    <= StReq;
          end
        end
        StReq: begin
          if (gnt_i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= is_store_op(r_op) ? StIdle : StResp;
          end
        end
        StResp: begin
          if (rvalid_i) begin
            r_wb_en   <= r_ld_wen;
            r_wb_addr <= r_ld_waddr;
            r_wb_data <= w_ld_data;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_o      = r_req;
  assign we_o       = r_we;
  assign addr_o     = r_addr;
  assign be_o       = r_be;
  assign wdata_o    = r_wdata;
  assign w_enable_o = r_wb_en;
  assign w_addr_o   = r_wb_addr;
  assign w_data_o   = r_wb_data;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage: pass-through, loads, stores, wait states, reset and misalignment.
module tb_mem_lsu_stage;
  import mem_lsu_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid_i, w_enable_i, gnt_i, rvalid_i;
  logic [4:0]  w_addr_i;
  logic [31:0] w_data_i, mem_addr_i, mem_wdata_i, rdata_i;
  logic [3:0]  mem_op_i;
  logic        stall_o, req_o, we_o, w_enable_o, exc_o;
  logic [31:0] addr_o, wdata_o, w_data_o, exc_addr_o;
  logic [3:0]  be_o;
  logic [4:0]  w_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_lsu_stage #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .w_enable_i  (w_enable_i),
    .w_addr_i    (w_addr_i),
    .w_data_i    (w_data_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .stall_o     (stall_o),
    .req_o       (req_o),
    .we_o        (we_o),
    .addr_o      (addr_o),
    .be_o        (be_o),
    .wdata_o     (wdata_o),
    .gnt_i       (gnt_i),
    .rvalid_i    (rvalid_i),
    .rdata_i     (rdata_i),
    .w_enable_o  (w_enable_o),
    .w_addr_o    (w_addr_o),
    .w_data_o    (w_data_o),
    .exc_o       (exc_o),
    .exc_addr_o  (exc_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load issued in IDLE; gw/rw are gnt and rvalid wait cycles.
  task automatic run_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                          input int gw, input int rw, input logic [4:0] rd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_data);
    valid_i = 1; mem_op_i = op; mem_addr_i = addr; w_addr_i = rd; w_enable_i = 1;
    w_data_i = 32'hDEAD_BEEF; mem_wdata_i = 32'h0;
    #1 chk("ld_accept_stall", stall_o, 1);
    cyc();
    for (int i = 0; i <= gw; i++) begin
      chk("ld_req", req_o, 1);
      chk("ld_we", we_o, 0);
      chk("ld_addr", addr_o, exp_addr);
      chk("ld_be", be_o, exp_be);
      gnt_i = (i == gw);
      #1 chk("ld_req_stall", stall_o, 1);
      cyc();
    end
    gnt_i = 0;
    for (int i = 0; i <= rw; i++) begin
      chk("ld_resp_req", req_o, 0);
      chk("ld_wait_wen", w_enable_o, 0);
      rvalid_i = (i == rw);
      rdata_i  = (i == rw) ? rdata : 32'h0;
      #1 chk("ld_resp_stall", stall_o, (i == rw) ? 1'b0 : 1'b1);
      cyc();
    end
    rvalid_i = 0; valid_i = 0;
    chk("ld_wen", w_enable_o, 1);
    chk("ld_waddr", w_addr_o, rd);
    chk("ld_wdata", w_data_o, exp_data);
    cyc();
    chk("ld_wen_pulse", w_enable_o, 0);
  endtask

  task automatic run_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input int gw, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
    valid_i = 1; mem_op_i = op; mem_addr_i = addr; mem_wdata_i = data;
    w_enable_i = 1; w_addr_i = 5'd3;
    #1 chk("st_accept_stall", stall_o, 1);
    cyc();
    for (int i = 0; i <= gw; i++) begin
      chk("st_req", req_o, 1);
      chk("st_we", we_o, 1);
      chk("st_addr", addr_o, exp_addr);
      chk("st_be", be_o, exp_be);
      chk("st_wdata", wdata_o, exp_wdata);
      chk("st_wen", w_enable_o, 0);
      gnt_i = (i == gw);
      #1 chk("st_stall", stall_o, (i == gw) ? 1'b0 : 1'b1);
      cyc();
    end
    gnt_i = 0; valid_i = 0;
    chk("st_done_req", req_o, 0);
    chk("st_done_wen", w_enable_o, 0);
  endtask

  initial begin
    rst = 0; valid_i = 0; w_enable_i = 0; gnt_i = 0; rvalid_i = 0;
    w_addr_i = 0; w_data_i = 0; mem_op_i = MemNone; mem_addr_i = 0; mem_wdata_i = 0; rdata_i = 0;
    #3;
    chk("rst_req", req_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_be", be_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wen", w_enable_o, 0);
    chk("rst_waddr", w_addr_o, 0);
    chk("rst_wdata_o", w_data_o, 0);
    chk("rst_exc", exc_o, 0);
    chk("rst_exc_addr", exc_addr_o, 0);
    cyc();
    rst = 1;
    cyc();

    // ALU pass-through
    valid_i = 1; mem_op_i = MemNone; w_enable_i = 1; w_addr_i = 5'd5; w_data_i = 32'h1234;
    #1 chk("alu_stall", stall_o, 0);
    cyc();
    chk("alu_wen", w_enable_o, 1);
    chk("alu_waddr", w_addr_o, 5);
    chk("alu_wdata", w_data_o, 32'h1234);
    valid_i = 0;
    cyc();
    chk("bubble_wen", w_enable_o, 0);

    // Stray gnt in IDLE is ignored
    gnt_i = 1;
    cyc();
    gnt_i = 0;
    chk("stray_gnt_req", req_o, 0);

    run_load(MemLb,  32'h103, 32'h80FF_0000, 0, 0, 5'd7, 32'h100, 4'b1000, 32'hFFFF_FF80);
    run_load(MemLbu, 32'h103, 32'h80FF_0000, 0, 0, 5'd8, 32'h100, 4'b1000, 32'h0000_0080);
    run_load(MemLh,  32'h202, 32'h8001_7FFF, 1, 0, 5'd9, 32'h200, 4'b1100, 32'hFFFF_8001);
    run_load(MemLhu, 32'h200, 32'h8001_F00F, 0, 2, 5'd10, 32'h200, 4'b0011, 32'h0000_F00F);
    run_load(MemLw,  32'h400, 32'hCAFE_F00D, 0, 4, 5'd11, 32'h400, 4'b1111, 32'hCAFE_F00D);

    run_store(MemSh, 32'h202, 32'hABCD_1234, 3, 32'h200, 4'b1100, 32'h1234_1234);
    run_store(MemSb, 32'h101, 32'h0000_00A5, 0, 32'h100, 4'b0010, 32'hA5A5_A5A5);
    run_store(MemSw, 32'h300, 32'h1357_9BDF, 1, 32'h300, 4'b1111, 32'h1357_9BDF);

    // Reset while waiting for rvalid abandons the load
    valid_i = 1; mem_op_i = MemLw; mem_addr_i = 32'h500; w_addr_i = 5'd12; w_enable_i = 1;
    cyc();
    gnt_i = 1;
    cyc();
    gnt_i = 0; valid_i = 0;
    rst = 0;
    #1;
    chk("rstresp_req", req_o, 0);
    chk("rstresp_addr", addr_o, 0);
    chk("rstresp_be", be_o, 0);
    chk("rstresp_waddr", w_addr_o, 0);
    chk("rstresp_wdata", w_data_o, 0);
    chk("rstresp_stall", stall_o, 0);
    cyc();
    rst = 1;
    rvalid_i = 1; rdata_i = 32'h5555_5555;
    cyc();
    rvalid_i = 0;
    chk("late_rvalid_wen", w_enable_o, 0);
    chk("late_rvalid_wdata", w_data_o, 0);
    cyc();
    chk("late_rvalid_wen2", w_enable_o, 0);

`ifdef MISALIGN_TRAP_EN
    valid_i = 1; mem_op_i = MemLw; mem_addr_i = 32'h102; w_addr_i = 5'd13; w_enable_i = 1;
    #1 chk("mis_stall", stall_o, 0);
    cyc();
    valid_i = 0;
    chk("mis_exc", exc_o, 1);
    chk("mis_exc_addr", exc_addr_o, 32'h102);
    chk("mis_req", req_o, 0);
    chk("mis_wen", w_enable_o, 0);
    cyc();
    chk("mis_exc_pulse", exc_o, 0);
    chk("mis_req2", req_o, 0);
`else
    run_load(MemLw, 32'h102, 32'h1122_3344, 0, 0, 5'd13, 32'h100, 4'b1111, 32'h1122_3344);
    chk("mis_exc_tied", exc_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
